// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM style bus bundle between a CPU memory-unit initiator and a word memory responder.
interface avalon_mem_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_mem_responder.sv
// Avalon-MM word memory with programmable wait states, used as CPU instruction+data memory.
// Each request is latched, stalled WAIT_CYCLES extra cycles, and initiator faults raise a sticky flag.
module avalon_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_mem_responder_if.slave bus,
  output logic                  protocol_error
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  counter_q, counter_d;
  logic [31:0] readData_q, readData_d;
  logic        protocolError_q, protocolError_d;
  logic [31:0] latchedAddr_q, latchedAddr_d;
  logic        latchedWrite_q, latchedWrite_d;
  logic [3:0]  latchedBe_q, latchedBe_d;
  logic [31:0] latchedData_q, latchedData_d;
  logic        memWe;

  logic [31:0] mem [DEPTH];

  logic [31:0]           byteOffset;
  logic [31:0]           wordOffset;
  logic                  outOfRange;
  logic [ADDR_WIDTH-1:0] memIdx;
  logic                  requestActive;
  logic                  requestChanged;

  // Wrap-around subtraction lets addresses below the base land far out of range.
  assign byteOffset = latchedAddr_q - BASE_ADDR;
  assign wordOffset = byteOffset >> 2;
  assign outOfRange = wordOffset >= 32'(DEPTH);
  assign memIdx     = wordOffset[ADDR_WIDTH-1:0];

  assign requestActive  = bus.read | bus.write;
  assign requestChanged = (bus.address != latchedAddr_q)
                        || (bus.write != latchedWrite_q)
                        || (bus.read != !latchedWrite_q)
                        || (bus.byteenable != latchedBe_q)
                        || (bus.writedata != latchedData_q);

  always_comb begin
    bus.waitrequest = 1'b1;
    if (!reset) begin
      unique case (state_q)
        IDLE:    bus.waitrequest = requestActive;
        BUSY:    bus.waitrequest = 1'b1;
        DONE:    bus.waitrequest = 1'b0;
        default: bus.waitrequest = 1'b1;
      endcase
    end
  end

  assign bus.readdata   = readData_q;
  assign protocol_error = protocolError_q;

  always_comb begin
    state_d         = state_q;
    counter_d       = counter_q;
    readData_d      = readData_q;
    protocolError_d = protocolError_q;
    latchedAddr_d   = latchedAddr_q;
    latchedWrite_d  = latchedWrite_q;
    latchedBe_d     = latchedBe_q;
    latchedData_d   = latchedData_q;
    memWe           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.read && bus.write) begin
          protocolError_d = 1'b1;
        end else if (requestActive) begin
          latchedAddr_d  = bus.address;
          latchedWrite_d = bus.write;
          latchedBe_d    = bus.byteenable;
          latchedData_d  = bus.writedata;
          counter_d      = 4'(WAIT_CYCLES);
          state_d        = BUSY;
        end
      end
      BUSY: begin
        if (!requestActive) begin
          protocolError_d = 1'b1;
          state_d         = IDLE;
        end else begin
          if (requestChanged) protocolError_d = 1'b1;
          if (counter_q != 4'd0) begin
            counter_d = counter_q - 4'd1;
          end else begin
            if (outOfRange) protocolError_d = 1'b1;
            if (!latchedWrite_q) readData_d = outOfRange ? 32'h0 : mem[memIdx];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!requestActive) begin
          protocolError_d = 1'b1;
        end else begin
          if (requestChanged) protocolError_d = 1'b1;
          memWe = latchedWrite_q && !outOfRange;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      counter_q       <= '0;
      readData_q      <= '0;
      protocolError_q <= 1'b0;
      latchedAddr_q   <= '0;
      latchedWrite_q  <= 1'b0;
      latchedBe_q     <= '0;
      latchedData_q   <= '0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      readData_q      <= readData_d;
      protocolError_q <= protocolError_d;
      latchedAddr_q   <= latchedAddr_d;
      latchedWrite_q  <= latchedWrite_d;
      latchedBe_q     <= latchedBe_d;
      latchedData_q   <= latchedData_d;
    end
  end

  // Memory contents survive reset; only the commit itself is suppressed.
  always_ff @(posedge clk) begin
    if (memWe && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (latchedBe_q[i]) mem[memIdx][8*i +: 8] <= latchedData_q[8*i +: 8];
      end
    end
  end
endmodule
